cnn_param_loader: RTL and testbench
===================================

// Module: cnn_param_loader
// PURPOSE
//  Sequences the one-time load of all CNN_tdm_top coefficient memories from a single 32-bit word stream.
//  - Memories loaded: L1 conv W/B, L2 conv W1/B1/W2/B2, vector W/B.
//  - Drives per-memory write enables, a shared address and shared write data.
//  - Holds the CNN in reset until every memory is loaded, then releases it.
//  - Sits between the host/config source and CNN_tdm_top, replacing ad-hoc init counters.
// PARAMETERS
//  DW      24   coefficient width; LD_DATA[DW-1:0] is written, upper bits dropped
//  N_L1W   36   L1 conv weights (9*4)
//  N_L1B   4    L1 conv biases
//  N_L2W   144  L2 conv weights per bank (9*4*4); used for W1 and W2
//  N_L2B   4    L2 conv biases per bank; used for B1 and B2
//  N_VW    768  vector weights (16*6*8)
//  N_VB    6    vector biases
// PORTS
//  CLK       in   1    clock
//  RSTn      in   1    synchronous active-low reset
//  START     in   1    1-cycle pulse: begin (re)load
//  LD_VALID  in   1    LD_DATA valid
//  LD_DATA   in   32   coefficient word, segment order below
//  LD_READY  out  1    loader accepts a word this cycle
//  WEN       out  8    one-hot write enable
//                      bit0 L1W, 1 L1B, 2 L2W1, 3 L2B1, 4 L2W2, 5 L2B2, 6 VW, 7 VB
//  ADDR      out  10   write address within the selected memory
//  WDATA     out  DW   write data
//  SEG       out  3    index of the segment currently being loaded
//  BUSY      out  1    load in progress (LOAD or FLUSH)
//  DONE      out  1    all memories loaded
//  CNN_RSTN  out  1    active-low reset to CNN_tdm_top; 1 only in DONE
// BEHAVIOUR
//  Reset values (RSTn=0 at a clock edge):
//   - FSM=IDLE; WEN=0; ADDR=0; WDATA=0; SEG=0; LD_READY=0; BUSY=0; DONE=0; CNN_RSTN=0.
//  FSM IDLE -> LOAD: on START.
//  FSM LOAD:
//   - LD_READY=1. A word is accepted when LD_VALID&LD_READY.
//   - Accepted word appears next cycle with exactly one registered WEN bit set:
//     WEN[SEG]=1, ADDR=addr counter, WDATA=LD_DATA[DW-1:0]. Latency 1 cycle.
//   - No accept -> WEN=0 next cycle; ADDR and WDATA hold their last value.
//   - Addr counter increments per accept.
//   - On accepting word N_seg-1: addr counter returns to 0 and SEG increments.
//   - Segment order/size: 0..7 = N_L1W, N_L1B, N_L2W, N_L2B, N_L2W, N_L2B, N_VW, N_VB.
//   - Total 1110 words at defaults.
//  FSM LOAD -> FLUSH: on accepting the last VB word (SEG=7, addr=N_VB-1).
//   - LD_READY drops the next cycle.
//  FSM FLUSH: 2 cycles, WEN=0. Guarantees the final write has landed before the CNN leaves reset.
//  FSM FLUSH -> DONE:
//   - DONE=1 and CNN_RSTN=1 registered on entry.
//   - BUSY=1 in LOAD and FLUSH only.
//  FSM DONE -> LOAD: on START (reload).
//   - CNN_RSTN=0, DONE=0, SEG=0, addr counter=0 on the next cycle.
//  START is ignored in LOAD and FLUSH. LD_VALID is ignored outside LOAD.
//  RSTn low mid-load: abort immediately to reset values. A subsequent START restarts from SEG 0, addr 0.
//  No overflow is possible: the addr counter is 10 bits and the largest segment is 768.
// STRUCTURE
//  Package cnn_param_pkg:
//   - seg_e enum (SEG_L1W..SEG_VB).
//   - Segment-size constant array indexed by seg_e.
//   - FSM state enum {IDLE, LOAD, FLUSH, DONE}.
//   - WEN bit positions.
//  Single module; no sub-module needed. Segment length is a combinational lookup of SEG.
//  Output regs feed CNN_tdm_top write ports directly. All *_REN tied 0 at the top level.
// TESTING
//  1. Reset then START, stream 1110 words with LD_VALID always 1, LD_DATA = word index:
//     - L1W gets addr 0..35 with data 0..35.
//     - VB addr 5 gets data 1109.
//     - CNN_RSTN rises 3 cycles after the last accept.
//  2. Boundary: after word 35 accepted -> next cycle WEN=8'h01, ADDR=35.
//     - Word 36 -> WEN=8'h02, ADDR=0, SEG=1.
//  3. LD_VALID toggled by random gaps:
//     - WEN=0 in every gap cycle.
//     - Written sequence is identical to scenario 1.
//  4. LD_DATA=32'hFFAB_CDEF -> WDATA=24'hABCDEF. Upper bits are discarded.
//  5. RSTn=0 for 1 cycle at word 500:
//     - All outputs reset.
//     - START plus a 1110-word reload completes correctly.
//  6. START while BUSY:
//     - No effect.
//     - START in DONE -> CNN_RSTN=0 next cycle and the reload begins at SEG 0.

Source files
------------

// File: rtl/cnn_param_loader_pkg.sv
// Shared types and constants for the CNN coefficient loader: segment map,
// FSM states and bus widths.
package cnn_param_pkg;

  localparam int unsigned DW     = 24;
  localparam int unsigned LD_W   = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WEN_W  = 8;
  localparam int unsigned SEG_W  = 3;

  localparam int unsigned N_L1W = 36;
  localparam int unsigned N_L1B = 4;
  localparam int unsigned N_L2W = 144;
  localparam int unsigned N_L2B = 4;
  localparam int unsigned N_VW  = 768;
  localparam int unsigned N_VB  = 6;

  // Idle cycles between the final write and releasing the CNN reset
  localparam int unsigned FLUSH_CYC = 2;

  typedef enum logic [SEG_W-1:0] {
    SEG_L1W, SEG_L1B, SEG_L2W1, SEG_L2B1, SEG_L2W2, SEG_L2B2, SEG_VW, SEG_VB
  } seg_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} state_e;

  localparam int unsigned WEN_L1W  = 0;
  localparam int unsigned WEN_L1B  = 1;
  localparam int unsigned WEN_L2W1 = 2;
  localparam int unsigned WEN_L2B1 = 3;
  localparam int unsigned WEN_L2W2 = 4;
  localparam int unsigned WEN_L2B2 = 5;
  localparam int unsigned WEN_VW   = 6;
  localparam int unsigned WEN_VB   = 7;

  localparam logic [ADDR_W-1:0] SEG_LEN [8] = '{
    ADDR_W'(N_L1W), ADDR_W'(N_L1B), ADDR_W'(N_L2W), ADDR_W'(N_L2B),
    ADDR_W'(N_L2W), ADDR_W'(N_L2B), ADDR_W'(N_VW),  ADDR_W'(N_VB)
  };

  function automatic logic [ADDR_W-1:0] seg_len(seg_e s);
    return SEG_LEN[s];
  endfunction

endpackage

// File: rtl/cnn_param_loader_if.sv
// Coefficient word stream: valid/ready handshake from the config source.
interface cnn_param_loader_if;
  import cnn_param_pkg::*;

  logic            ld_valid;
  logic [LD_W-1:0] ld_data;
  logic            ld_ready;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/cnn_param_loader.sv
// Streams coefficient words into the CNN_tdm_top memories in fixed segment
// order and holds the CNN in reset until the last write has landed.
module cnn_param_loader
  import cnn_param_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  cnn_param_loader_if.slave    ld,
  output logic [WEN_W-1:0]     wen,
  output logic [ADDR_W-1:0]    addr,
  output logic [DW-1:0]        wdata,
  output logic [SEG_W-1:0]     seg,
  output logic                 busy,
  output logic                 done,
  output logic                 cnn_rstn
);

  state_e            state;
  seg_e              seg_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic [1:0]        flush_cnt;
  logic              ld_ready_q;
  logic              accept;
  logic              seg_end;
  logic              unused_ld_hi;

  assign ld.ld_ready  = ld_ready_q;
  assign seg          = SEG_W'(seg_q);
  assign accept       = (state == ST_LOAD) && ld_ready_q && ld.ld_valid;
  assign seg_end      = (addr_cnt == (seg_len(seg_q) - ADDR_W'(1)));
  assign unused_ld_hi = ^ld.ld_data[LD_W-1:DW];

  // Loader FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      seg_q      <= SEG_L1W;
      addr_cnt   <= '0;
      flush_cnt  <= '0;
      ld_ready_q <= 1'b0;
      wen        <= '0;
      addr       <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnn_rstn   <= 1'b0;
    end else begin
      wen <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_LOAD;
            seg_q      <= SEG_L1W;
            addr_cnt   <= '0;
            ld_ready_q <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            cnn_rstn   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            wen   <= WEN_W'(1) << seg_q;
            addr  <= addr_cnt;
            wdata <= ld.ld_data[DW-1:0];
            if (seg_end) begin
              addr_cnt <= '0;
              // SEG holds at VB once the final segment completes
              if (seg_q == SEG_VB) begin
                state      <= ST_FLUSH;
                ld_ready_q <= 1'b0;
                flush_cnt  <= '0;
              end else begin
                seg_q <= seg_e'(SEG_W'(seg_q) + SEG_W'(1));
              end
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 2'(FLUSH_CYC)) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cnn_rstn <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_param_loader.sv
// Self-checking bench for cnn_param_loader: full loads with and without
// handshake gaps, segment boundaries, data truncation, reset abort, reload.
module tb_cnn_param_loader;

  localparam int TOTAL = 1110;

  typedef struct packed {
    logic [7:0]  wen;
    logic [9:0]  addr;
    logic [23:0] data;
    logic [2:0]  seg;
  } wr_t;

  typedef struct {
    int         k;
    logic [7:0] wen;
    logic [9:0] addr;
    logic [2:0] seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  wen;
  logic [9:0]  addr;
  logic [23:0] wdata;
  logic [2:0]  seg;
  logic        busy, done, cnn_rstn;

  cnn_param_loader_if ld_if ();

  cnn_param_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ld       (ld_if),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .seg      (seg),
    .busy     (busy),
    .done     (done),
    .cnn_rstn (cnn_rstn)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          sz_tab [8] = '{36, 4, 144, 4, 144, 4, 768, 6};
  logic [31:0] stim [$];
  wr_t         dut_log [$];
  bit          mon_en = 1'b0;
  bit          prev_acc = 1'b0;
  int          gap_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Writes must appear exactly one cycle after each handshake
  always @(negedge clk) begin
    if (mon_en) begin
      if ((wen != 8'h00) !== prev_acc) gap_err++;
      if (wen != 8'h00) dut_log.push_back('{wen: wen, addr: addr, data: wdata, seg: seg});
      prev_acc = ld_if.ld_valid && ld_if.ld_ready && rst_n;
    end
  end

  // Reference: word k lands in the segment whose cumulative range holds k
  function automatic wr_t model_wr(input int k, input logic [31:0] d);
    wr_t r;
    int  s = 0;
    int  off = 0;
    while (s < 7 && k >= off + sz_tab[s]) begin
      off += sz_tab[s];
      s++;
    end
    r.wen  = 8'(1) << s;
    r.addr = 10'(k - off);
    r.data = d[23:0];
    r.seg  = (k == off + sz_tab[s] - 1 && s < 7) ? 3'(s + 1) : 3'(s);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_stim(input bit rand_hi);
    stim.delete();
    for (int k = 0; k < TOTAL; k++)
      stim.push_back(rand_hi ? {8'($urandom), 24'(k)} : 32'(k));
  endtask

  task automatic send_word(input logic [31:0] d, input int gap_max, output bit ok);
    int gaps;
    bit rdy;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    ld_if.ld_valid = 1'b0;
    repeat (gaps) tick();
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = d;
    ok = 1'b0;
    for (int g = 0; g < 16; g++) begin
      rdy = ld_if.ld_ready;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    ld_if.ld_valid = 1'b0;
  endtask

  task automatic run_stream(input int n, input int gap_max, input int start_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (i == start_at) start = 1'b1;
      send_word(stim[i], gap_max, ok);
      start = 1'b0;
      if (!ok) begin
        check($sformatf("ready_timeout_word_%0d", i), 32'(ok), 32'd1);
        return;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered just after the last accepting edge; counts edges until CNN reset release
  task automatic check_finish(input string name, input bit poke_start);
    int lat = 0;
    check({name, "_ready_drop"}, 32'(ld_if.ld_ready), 32'd0);
    check({name, "_busy_flush"}, 32'(busy), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      if (poke_start && c == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (cnn_rstn === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({name, "_cnn_rstn_latency"}, 32'(lat), 32'd3);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic compare_log(input string name, input int n);
    int  nbad = 0;
    int  first = -1;
    int  lim;
    wr_t e;
    check({name, "_write_count"}, 32'(dut_log.size()), 32'(n));
    lim = (dut_log.size() < n) ? dut_log.size() : n;
    for (int k = 0; k < lim; k++) begin
      e = model_wr(k, stim[k]);
      if (dut_log[k] !== e) begin
        nbad++;
        if (first < 0) first = k;
      end
    end
    check($sformatf("%s_bad_writes_first_at_%0d", name, first), 32'(nbad), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_wen"},      32'(wen), 32'd0);
    check({name, "_addr"},     32'(addr), 32'd0);
    check({name, "_wdata"},    32'(wdata), 32'd0);
    check({name, "_seg"},      32'(seg), 32'd0);
    check({name, "_ld_ready"}, 32'(ld_if.ld_ready), 32'd0);
    check({name, "_busy"},     32'(busy), 32'd0);
    check({name, "_done"},     32'(done), 32'd0);
    check({name, "_cnn_rstn"}, 32'(cnn_rstn), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    vecs[0]  = '{0,    8'h01, 10'd0,   3'd0};
    vecs[1]  = '{35,   8'h01, 10'd35,  3'd1};
    vecs[2]  = '{36,   8'h02, 10'd0,   3'd1};
    vecs[3]  = '{39,   8'h02, 10'd3,   3'd2};
    vecs[4]  = '{40,   8'h04, 10'd0,   3'd2};
    vecs[5]  = '{183,  8'h04, 10'd143, 3'd3};
    vecs[6]  = '{184,  8'h08, 10'd0,   3'd3};
    vecs[7]  = '{188,  8'h10, 10'd0,   3'd4};
    vecs[8]  = '{332,  8'h20, 10'd0,   3'd5};
    vecs[9]  = '{336,  8'h40, 10'd0,   3'd6};
    vecs[10] = '{1103, 8'h40, 10'd767, 3'd7};
    vecs[11] = '{1104, 8'h80, 10'd0,   3'd7};
    vecs[12] = '{1109, 8'h80, 10'd5,   3'd7};

    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_vals("por");
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Back-to-back full load, data = word index
    fill_stim(1'b0);
    dut_log.delete();
    pulse_start();
    check("s1_ready_after_start", 32'(ld_if.ld_ready), 32'd1);
    check("s1_busy_after_start", 32'(busy), 32'd1);
    run_stream(TOTAL, 0, -1);
    check_finish("s1", 1'b0);
    compare_log("s1", TOTAL);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].k < dut_log.size()) begin
        check($sformatf("vec_k%0d_wen", vecs[i].k),  32'(dut_log[vecs[i].k].wen),  32'(vecs[i].wen));
        check($sformatf("vec_k%0d_addr", vecs[i].k), 32'(dut_log[vecs[i].k].addr), 32'(vecs[i].addr));
        check($sformatf("vec_k%0d_seg", vecs[i].k),  32'(dut_log[vecs[i].k].seg),  32'(vecs[i].seg));
        check($sformatf("vec_k%0d_data", vecs[i].k), 32'(dut_log[vecs[i].k].data), 32'(vecs[i].k));
      end else begin
        check($sformatf("vec_k%0d_present", vecs[i].k), 32'(dut_log.size()), 32'(vecs[i].k + 1));
      end
    end

    // Random gaps, random upper bits, START pulses during LOAD and FLUSH
    fill_stim(1'b1);
    dut_log.delete();
    pulse_start();
    run_stream(TOTAL, 3, 300);
    check_finish("s3", 1'b1);
    compare_log("s3", TOTAL);

    // START in DONE restarts immediately from segment 0
    pulse_start();
    check("reload_cnn_rstn", 32'(cnn_rstn), 32'd0);
    check("reload_done", 32'(done), 32'd0);
    check("reload_seg", 32'(seg), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
    check("reload_ready", 32'(ld_if.ld_ready), 32'd1);

    // Upper bits discarded, then abort with reset after word 500
    fill_stim(1'b0);
    stim[0] = 32'hFFAB_CDEF;
    dut_log.delete();
    run_stream(500, 1, -1);
    if (dut_log.size() > 0) begin
      check("trunc_wdata", 32'(dut_log[0].data), 32'h00AB_CDEF);
      check("trunc_wen", 32'(dut_log[0].wen), 32'h01);
      check("trunc_addr", 32'(dut_log[0].addr), 32'd0);
    end else begin
      check("trunc_write_present", 32'(dut_log.size()), 32'd1);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_vals("abort");

    fill_stim(1'b0);
    dut_log.delete();
    pulse_start();
    run_stream(TOTAL, 1, -1);
    check_finish("s5", 1'b0);
    compare_log("s5", TOTAL);

    tick();
    check("wen_only_after_accept", 32'(gap_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
